// File: rtl/cam_read_if.sv
// Camera-side byte stream plus frame-buffer write port of cam_read.
// Combinational bundle only; no storage and no backpressure (PCLK-paced).
// The master modport belongs to the camera/frame-buffer side, the slave modport to cam_read.
interface cam_read_if #(
    parameter int AW = 15,
    parameter int DW = 3
);
    logic          init;
    logic          vsync;
    logic          href;
    logic [7:0]    px_data;
    logic [AW-1:0] mem_px_addr;
    logic [DW-1:0] mem_px_data;
    logic          px_wr;
    logic          done;

    modport master (
        output init, vsync, href, px_data,
        input  mem_px_addr, mem_px_data, px_wr, done
    );

    modport slave (
        input  init, vsync, href, px_data,
        output mem_px_addr, mem_px_data, px_wr, done
    );
endinterface

// File: rtl/cam_read.sv
// Captures RGB565 camera frames as RGB111 pixels into a frame buffer; optional frame counter under CAM_READ_FRAME_CNT_EN.
// Latency: write strobe, data and address appear one clk_w cycle after the second byte of a pixel is sampled.
// No backpressure: the camera free-runs and the frame buffer must accept one write per px_wr pulse; NPIX <= 2**AW.
module cam_read #(
    parameter int AW   = 15,
    parameter int DW   = 3,
    parameter int NPIX = 19200
) (
    input  logic       clk_w,
    input  logic       rst,
    cam_read_if.slave  cam
`ifdef CAM_READ_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VS,
        WAIT_FRAME,
        BYTE1,
        BYTE2
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

    state_t        state_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic          wr_q;
    logic          done_q;
    logic          r_q;
    logic          g_q;
    logic          full_q;
    logic          end_pend_q;
    logic          px_unused;

    assign px_unused = ^{cam.px_data[6:5], cam.px_data[3], cam.px_data[1:0]};

    always_ff @(posedge clk_w) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            wr_q       <= 1'b0;
            done_q     <= 1'b0;
            r_q        <= 1'b0;
            g_q        <= 1'b0;
            full_q     <= 1'b0;
            end_pend_q <= 1'b0;
        end else begin
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            // Address advances after each write, except once the last slot has been written.
            if (wr_q && !full_q) begin
                addr_q <= addr_q + AW'(1);
            end
            case (state_q)
                IDLE: begin
                    if (cam.init) begin
                        state_q <= WAIT_VS;
                    end
                end
                WAIT_VS: begin
                    if (cam.vsync) begin
                        state_q <= WAIT_FRAME;
                    end
                end
                WAIT_FRAME: begin
                    if (!cam.vsync) begin
                        addr_q     <= '0;
                        full_q     <= 1'b0;
                        end_pend_q <= 1'b0;
                        state_q    <= BYTE1;
                    end
                end
                BYTE1: begin
                    if (end_pend_q || cam.vsync) begin
                        done_q     <= 1'b1;
                        end_pend_q <= 1'b0;
                        state_q    <= cam.init ? WAIT_FRAME : IDLE;
                    end else if (cam.href && !full_q) begin
                        r_q     <= cam.px_data[7];
                        g_q     <= cam.px_data[2];
                        state_q <= BYTE2;
                    end
                end
                BYTE2: begin
                    if (cam.href) begin
                        data_q  <= DW'({r_q, g_q, cam.px_data[4]});
                        wr_q    <= 1'b1;
                        full_q  <= (addr_q == LAST_ADDR);
                        // A pixel completing as vsync rises is written first; done follows a cycle later.
                        end_pend_q <= cam.vsync;
                        state_q    <= BYTE1;
                    end else if (cam.vsync) begin
                        done_q  <= 1'b1;
                        state_q <= cam.init ? WAIT_FRAME : IDLE;
                    end else begin
                        state_q <= BYTE1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cam.mem_px_addr = addr_q;
    assign cam.mem_px_data = data_q;
    assign cam.px_wr       = wr_q;
    assign cam.done        = done_q;

`ifdef CAM_READ_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    always_ff @(posedge clk_w) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (done_q) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: doc/cam_read.md
CAM_READ -- requirements
Module: cam_read

Interface
REQ-001 Parameter AW, default 15, pixel address width in bits.
REQ-002 Parameter DW, default 3, pixel data width in bits (RGB111).
REQ-003 Parameter NPIX, default 19200, pixels per frame (160x120); the block SHALL require NPIX <= 2**AW.
REQ-004 clk_w  input  1  single clock, driven by the camera PCLK; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 init  input  1  capture enable; high requests frame capture.
REQ-007 vsync  input  1  camera frame sync; high means vertical blank.
REQ-008 href  input  1  camera line valid; high means px_data carries a valid byte.
REQ-009 px_data  input  8  camera byte stream in RGB565 (first byte RRRRRGGG, second byte GGGBBBBB).
REQ-010 mem_px_addr  output  AW  write address toward the frame buffer.
REQ-011 mem_px_data  output  DW  RGB111 pixel toward the frame buffer.
REQ-012 px_wr  output  1  frame-buffer write strobe, one cycle per pixel.
REQ-013 done  output  1  one-cycle pulse at end of a captured frame.

Function
REQ-014 The FSM SHALL use the states IDLE, WAIT_VS, WAIT_FRAME, BYTE1 and BYTE2.
REQ-015 IDLE: the FSM SHALL go to WAIT_VS when init=1.
REQ-016 WAIT_VS: the FSM SHALL wait for vsync=1, then go to WAIT_FRAME.
REQ-017 WAIT_FRAME: on vsync falling (vsync=0), the FSM SHALL clear mem_px_addr to 0 and go to BYTE1.
REQ-018 BYTE1 with href=1: the FSM SHALL latch R=px_data[7] and G=px_data[2], then go to BYTE2.
REQ-019 BYTE2 with href=1: the FSM SHALL register mem_px_data={R,G,px_data[4]} and assert px_wr=1 for exactly the following cycle, then return to BYTE1.
REQ-020 Latency: px_wr, mem_px_data and mem_px_addr SHALL be valid together one clk_w cycle after the second byte is sampled.
REQ-021 mem_px_addr SHALL increment by 1 on the cycle after each px_wr pulse; pixel k SHALL be written at address k.
REQ-022 href low in BYTE2 SHALL discard the half pixel, issue no write, and return to BYTE1 without incrementing the address.
REQ-023 href low in BYTE1 SHALL hold state with no write.
REQ-024 After the write to address NPIX-1, further bytes in that frame SHALL be ignored; the address SHALL hold at NPIX-1 and never wrap within a frame.
REQ-025 vsync=1 while in BYTE1 or BYTE2 (end of frame) SHALL pulse done for one cycle.
REQ-026 After that done pulse, the FSM SHALL go to WAIT_FRAME if init=1, otherwise to IDLE.
REQ-027 A frame shorter than NPIX pixels SHALL still pulse done.
REQ-028 init deasserted mid-frame SHALL NOT abort the frame; capture SHALL continue to the frame end, then go to IDLE.
REQ-029 If vsync rises in the same cycle as a valid second byte, the pixel SHALL be written before done is asserted.
REQ-030 px_wr SHALL never be high in IDLE, WAIT_VS or WAIT_FRAME.

Reset
REQ-031 rst=1 on a clock edge SHALL force state IDLE, mem_px_addr=0, mem_px_data=0, px_wr=0, done=0 and clear the latched R/G.
REQ-032 rst asserted mid-frame SHALL abort the capture with no further writes; after rst is released, capture SHALL restart only from the next vsync via WAIT_VS.

Configuration
REQ-033 Macro CAM_READ_FRAME_CNT_EN: when defined, the block SHALL add output frame_cnt [7:0].
REQ-034 frame_cnt SHALL be 0 after reset, SHALL increment on every done pulse, and SHALL wrap from 255 to 0.
REQ-035 When CAM_READ_FRAME_CNT_EN is not defined, the frame_cnt port and its counter SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-036 init=1, vsync pulse, then 2 lines of 160 pixels, byte pair 0xF8,0x1F -> 320 writes of data 3'b101 at addresses 0..319; done pulses once at vsync.
REQ-037 Byte pair 0x07,0xE0 -> data 3'b010; byte pair 0x00,0x10 -> data 3'b001; px_wr follows the second byte by exactly 1 cycle.
REQ-038 href drops after a single byte at address 5 -> no write; the next full pair is written at address 5.
REQ-039 Frame of 19300 pixels -> last write at 19199; no write beyond it; done still pulses at vsync.
REQ-040 rst pulsed at pixel 1000 -> px_wr=0 and addr=0 from the next cycle; the next frame starts writing at address 0.
REQ-041 With CAM_READ_FRAME_CNT_EN defined, 257 frames -> frame_cnt=1; without the macro -> the build has no frame_cnt port.
